// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and memory results onto the register file write port.
// Also tracks pending loads so decode can stall on read-after-load hazards.
module regfile_writeback #(
    parameter int WIDTH_DATA = 32,
    parameter int LENGTH = 32
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic                      alu_valid_i,
    input  logic [$clog2(LENGTH)-1:0] alu_rd_i,
    input  logic [WIDTH_DATA-1:0]     alu_data_i,
    input  logic                      mem_valid_i,
    output logic                      mem_ready_o,
    input  logic [$clog2(LENGTH)-1:0] mem_rd_i,
    input  logic [WIDTH_DATA-1:0]     mem_data_i,
    input  logic                      issue_valid_i,
    input  logic [$clog2(LENGTH)-1:0] issue_rd_i,
    input  logic [$clog2(LENGTH)-1:0] rs1_i,
    input  logic [$clog2(LENGTH)-1:0] rs2_i,
    output logic                      stall_o,
    output logic                      reg_write_o,
    output logic [$clog2(LENGTH)-1:0] wr_register_o,
    output logic [WIDTH_DATA-1:0]     wr_data_o
);
    localparam int W_ADDR = $clog2(LENGTH);
    logic                  buf_full;
    logic [W_ADDR-1:0]     buf_rd;
    logic [WIDTH_DATA-1:0] buf_data;
    logic                  from_mem;
    logic [LENGTH-1:0]     busy;
    logic [LENGTH-1:0]     busy_next;
    logic                  mem_hs;
    logic                  sel_valid;
    logic                  sel_mem;
    logic                  sel_wr;
    logic [W_ADDR-1:0]     sel_rd;
    logic [WIDTH_DATA-1:0] sel_data;

    assign mem_ready_o = reset_n_i & ~buf_full;
    assign mem_hs      = mem_valid_i & mem_ready_o;
    assign stall_o     = busy[rs1_i] | busy[rs2_i];

    // ALU never stalls, so it always wins; a buffered result drains before any new accept.
    always_comb begin
        sel_valid = alu_valid_i | buf_full | mem_hs;
        sel_mem   = ~alu_valid_i & (buf_full | mem_hs);
        sel_rd    = alu_valid_i ? alu_rd_i : buf_full ? buf_rd : mem_rd_i;
        sel_data  = alu_valid_i ? alu_data_i : buf_full ? buf_data : mem_data_i;
        sel_wr    = sel_valid & (sel_rd != '0);
    end

    // A set on the same edge as a clear must win, so it is applied last.
    always_comb begin
        busy_next = busy;
        if (reg_write_o && from_mem) busy_next[wr_register_o] = 1'b0;
        if (issue_valid_i) busy_next[issue_rd_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            buf_full      <= 1'b0;
            buf_rd        <= '0;
            buf_data      <= '0;
            reg_write_o   <= 1'b0;
            wr_register_o <= '0;
            wr_data_o     <= '0;
            from_mem      <= 1'b0;
            busy          <= '0;
        end else begin
            if (mem_hs && alu_valid_i) begin
                buf_full <= 1'b1;
                buf_rd   <= mem_rd_i;
                buf_data <= mem_data_i;
            end else if (buf_full && !alu_valid_i) begin
                buf_full <= 1'b0;
            end
            reg_write_o <= sel_wr;
            if (sel_wr) begin
                wr_register_o <= sel_rd;
                wr_data_o     <= sel_data;
            end
            from_mem <= sel_mem;
            busy     <= busy_next;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenarios with a queue scoreboard of committed writes.
module tb_regfile_writeback;
    logic        clock_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic        stall_o;
    logic        reg_write_o;
    logic [4:0]  wr_register_o;
    logic [31:0] wr_data_o;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];
    logic [36:0] obs_q[$];

    regfile_writeback #(.WIDTH_DATA(32), .LENGTH(32)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .stall_o(stall_o),
        .reg_write_o(reg_write_o), .wr_register_o(wr_register_o), .wr_data_o(wr_data_o)
    );

    always #5 clock_i = ~clock_i;

    // Advance one edge and record any write the DUT presents to the register file.
    task automatic step();
        @(posedge clock_i);
        #1;
        if (reg_write_o === 1'b1) obs_q.push_back({wr_register_o, wr_data_o});
    endtask

    task automatic test_reset();
        rs1_i = 5'd3;
        rs2_i = 5'd17;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({reg_write_o, wr_register_o, wr_data_o, mem_ready_o, stall_o} !== 39'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got we=%b rd=%0d data=%h ready=%b stall=%b, want all 0",
                         i, reg_write_o, wr_register_o, wr_data_o, mem_ready_o, stall_o);
            end
        end
        reset_n_i = 1'b1;
        step();
        checks++;
        if (mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", mem_ready_o);
        end
        for (int r = 0; r < 32; r += 5) begin
            rs1_i = 5'(r);
            rs2_i = 5'(31 - r);
            #1;
            checks++;
            if (stall_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_stall rs1=%0d rs2=%0d: got %b want 0", rs1_i, rs2_i, stall_o);
            end
        end
        rs1_i = '0;
        rs2_i = '0;
    endtask

    task automatic test_alu_write();
        alu_valid_i = 1'b1;
        alu_rd_i = 5'd5;
        alu_data_i = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        alu_valid_i = 1'b0;
        checks++;
        if ({reg_write_o, wr_register_o, wr_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL alu_write: got we=%b rd=%0d data=%h want we=1 rd=5 data=deadbeef",
                     reg_write_o, wr_register_o, wr_data_o);
        end
        step();
        checks++;
        if (reg_write_o !== 1'b0) begin
            errors++;
            $display("FAIL alu_write_idle: got we=%b want 0", reg_write_o);
        end
    endtask

    task automatic test_collision();
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h11;
        mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_data_i = 32'h22;
        exp_q.push_back({5'd3, 32'h11});
        step();
        mem_valid_i = 1'b0;
        alu_rd_i = 5'd11; alu_data_i = 32'hA1;
        exp_q.push_back({5'd11, 32'hA1});
        checks++;
        if (mem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready_full1: got %b want 0", mem_ready_o);
        end
        step();
        alu_rd_i = 5'd12; alu_data_i = 32'hA2;
        exp_q.push_back({5'd12, 32'hA2});
        checks++;
        if (mem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready_full2: got %b want 0", mem_ready_o);
        end
        step();
        alu_valid_i = 1'b0;
        exp_q.push_back({5'd7, 32'h22});
        checks++;
        if (mem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready_full3: got %b want 0", mem_ready_o);
        end
        step();
        checks++;
        if ({reg_write_o, wr_register_o, wr_data_o, mem_ready_o} !== {1'b1, 5'd7, 32'h22, 1'b1}) begin
            errors++;
            $display("FAIL collision_drain: got we=%b rd=%0d data=%h ready=%b want we=1 rd=7 data=22 ready=1",
                     reg_write_o, wr_register_o, wr_data_o, mem_ready_o);
        end
        step();
    endtask

    task automatic test_load_hazard();
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        rs1_i = 5'd9; rs2_i = 5'd0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL hazard_before_issue: got %b want 0", stall_o);
        end
        step();
        issue_valid_i = 1'b0;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL hazard_stall_set: got %b want 1", stall_o);
        end
        step();
        mem_valid_i = 1'b1; mem_rd_i = 5'd9; mem_data_i = 32'h99;
        exp_q.push_back({5'd9, 32'h99});
        #1;
        checks++;
        if ({stall_o, mem_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL hazard_wait: got stall=%b ready=%b want 1 1", stall_o, mem_ready_o);
        end
        step();
        mem_valid_i = 1'b0;
        checks++;
        if ({reg_write_o, wr_register_o, stall_o} !== {1'b1, 5'd9, 1'b1}) begin
            errors++;
            $display("FAIL hazard_commit: got we=%b rd=%0d stall=%b want we=1 rd=9 stall=1",
                     reg_write_o, wr_register_o, stall_o);
        end
        step();
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL hazard_release: got %b want 0", stall_o);
        end
    endtask

    task automatic test_x0_set_clear();
        mem_valid_i = 1'b1; mem_rd_i = 5'd0; mem_data_i = 32'h55;
        #1;
        checks++;
        if (mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL x0_handshake: got ready=%b want 1", mem_ready_o);
        end
        step();
        mem_valid_i = 1'b0;
        checks++;
        if ({reg_write_o, mem_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL x0_no_write: got we=%b ready=%b want we=0 ready=1", reg_write_o, mem_ready_o);
        end
        issue_valid_i = 1'b1; issue_rd_i = 5'd4; rs1_i = 5'd4; rs2_i = 5'd0;
        step();
        issue_valid_i = 1'b0;
        mem_valid_i = 1'b1; mem_rd_i = 5'd4; mem_data_i = 32'h44;
        exp_q.push_back({5'd4, 32'h44});
        step();
        mem_valid_i = 1'b0;
        issue_valid_i = 1'b1;
        step();
        issue_valid_i = 1'b0;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_over_clear: got stall=%b want 1", stall_o);
        end
        mem_valid_i = 1'b1; mem_data_i = 32'h45;
        exp_q.push_back({5'd4, 32'h45});
        step();
        mem_valid_i = 1'b0;
        step();
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reissue_release: got stall=%b want 0", stall_o);
        end
    endtask

    task automatic test_mid_reset();
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h77;
        mem_valid_i = 1'b1; mem_rd_i = 5'd2; mem_data_i = 32'hBAD;
        issue_valid_i = 1'b1; issue_rd_i = 5'd6;
        exp_q.push_back({5'd1, 32'h77});
        step();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0; issue_valid_i = 1'b0;
        reset_n_i = 1'b0;
        rs1_i = 5'd6; rs2_i = 5'd0;
        #1;
        checks++;
        if ({mem_ready_o, stall_o} !== 2'b01) begin
            errors++;
            $display("FAIL mid_reset_before: got ready=%b stall=%b want ready=0 stall=1", mem_ready_o, stall_o);
        end
        step();
        reset_n_i = 1'b1;
        checks++;
        if ({reg_write_o, wr_register_o, wr_data_o, stall_o} !== 39'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got we=%b rd=%0d data=%h stall=%b want all 0",
                     reg_write_o, wr_register_o, wr_data_o, stall_o);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({mem_ready_o, stall_o, reg_write_o} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_after: got ready=%b stall=%b we=%b want 1 0 0", mem_ready_o, stall_o, reg_write_o);
        end
    endtask

    task automatic test_write_order();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL write_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [36:0] e;
            logic [36:0] o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL write_order: got rd=%0d data=%h want rd=%0d data=%h", o[36:32], o[31:0], e[36:32], e[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_collision();
        test_load_hazard();
        test_x0_set_clear();
        test_mid_reset();
        test_write_order();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
